seq_encoder: RTL and testbench

//   Encoder counterpart of the 3-to-8 decoder used in the lab designs.
//   - Accepts an N-bit multi-hot vector over a valid/ready handshake.
//   - Emits the W-bit index of every set bit, lowest index first, one index per output handshake.
//   - Marks the final index of each vector with out_last.
//   - Sits between request-generating logic and anything that consumes binary codes, e.g. a decoder.

---
 rtl/seq_encoder.sv | 130 +++++++++++++
 tb/tb_seq_encoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_encoder.sv
// -----------------------------------------------------------------------------
// seq_encoder
//   Serialising priority encoder, the encoder counterpart of the lab 3-to-8
//   decoder. A multi-hot vector is taken over a valid/ready handshake. The
//   block then emits the index of every set bit, lowest index first, with one
//   index per output handshake. The final index of each vector carries
//   out_last_o. An all-zero vector produces a single beat with out_none_o set.
//
// Ports
//   clk          in   1  single clock, rising edge
//   rst_n        in   1  asynchronous reset, active-low
//   in_valid_i   in   1  in_vec_i is valid
//   in_ready_o   out  1  block can accept a vector (IDLE)
//   in_vec_i     in   N  multi-hot request vector
//   out_valid_o  out  1  out_idx_o / out_last_o / out_none_o are valid
//   out_ready_i  in   1  consumer accepts the current output
//   out_idx_o    out  W  index of the lowest still-pending set bit
//   out_last_o   out  1  out_idx_o is the last set bit of this vector
//   out_none_o   out  1  the captured vector was all zeros
//   busy_o       out  1  a vector is held (state != IDLE)
// -----------------------------------------------------------------------------
module seq_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] in_vec_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_idx_o,
  output logic         out_last_o,
  output logic         out_none_o,
  output logic         busy_o
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic           none_q, none_d;

  logic [W-1:0]   lowIdx;
  logic [N-1:0]   pendLowCleared;
  logic           atMostOne;

  // Priority encode of the pending bits. Scanning from the top down lets the
  // lowest set bit win, and an empty vector falls through to index 0.
  always_comb begin
    lowIdx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        lowIdx = W'(i);
      end
    end
  end

  // Clearing the lowest set bit with x & (x-1). If the result is zero, then at
  // most one bit was pending, so the current beat is the last one. This also
  // covers the all-zero vector.
  assign pendLowCleared = pend_q & (pend_q - N'(1));
  assign atMostOne      = (pendLowCleared == '0);

  // Next-state and output decode. Outputs depend only on the registered state
  // and pending bits, so there is no combinational path from in_* to out_*.
  // In IDLE, every output except in_ready_o stays at its zero default.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    none_d      = none_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_idx_o   = '0;
    out_last_o  = 1'b0;
    out_none_o  = 1'b0;
    busy_o      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          pend_d  = in_vec_i;
          none_d  = (in_vec_i == '0);
          state_d = EMIT;
        end
      end

      EMIT: begin
        out_valid_o = 1'b1;
        busy_o      = 1'b1;
        out_idx_o   = lowIdx;
        out_last_o  = atMostOne;
        out_none_o  = none_q;
        if (out_ready_i) begin
          if (atMostOne) begin
            pend_d  = '0;
            none_d  = 1'b0;
            state_d = IDLE;
          end else begin
            pend_d  = pendLowCleared;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. An asynchronous reset drops any vector that is in flight,
  // and nothing more is emitted for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      none_q  <= none_d;
    end
  end

endmodule

// File: tb/tb_seq_encoder.sv
// -----------------------------------------------------------------------------
// tb_seq_encoder
//   Directed bench for seq_encoder (N=8, W=3). The bench drives inputs and
//   samples outputs on the falling clock edge, so the DUT registers update on
//   the rising edge in between.
// -----------------------------------------------------------------------------
module tb_seq_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] in_vec_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [2:0] out_idx_o;
  logic       out_last_o;
  logic       out_none_o;
  logic       busy_o;

  int compared   = 0;
  int mismatched = 0;

  // One record per vector: the input, how many beats it must produce, whether
  // it is the zero vector, and the expected index for each beat (beat 0 in
  // the low slot).
  typedef struct packed {
    logic [7:0]      vec;
    logic [3:0]      beats;
    logic            none;
    logic [7:0][2:0] idxs;
  } vec_t;

  vec_t tbl [6];

  seq_encoder #(.N(8), .W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_vec_i    (in_vec_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_idx_o   (out_idx_o),
    .out_last_o  (out_last_o),
    .out_none_o  (out_none_o),
    .busy_o      (busy_o)
  );

  // 10-unit clock, with the first rising edge at t=5.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: every check goes through here, so the counters
  // and the FAIL line format stay in one place.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual,
               expected, $time);
    end
  endtask

  // Present a vector once the DUT is ready and hold it for one capture edge.
  // The wait for in_ready_o has a bound so that a stuck DUT still lets the
  // bench reach its summary.
  task automatic applyStimulus(input logic [7:0] vec);
    int waited = 0;
    while (!in_ready_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("in_ready_timeout", 32'(in_ready_o), 32'd1);
    in_valid_i = 1'b1;
    in_vec_i   = vec;
    @(negedge clk);
    in_valid_i = 1'b0;
    in_vec_i   = 8'h5A;
  endtask

  // Drain one vector with out_ready held high. The beats must arrive on
  // consecutive cycles, and IDLE must follow directly after the last beat.
  task automatic runVector(input vec_t r);
    out_ready_i = 1'b1;
    applyStimulus(r.vec);
    for (int b = 0; b < int'(r.beats); b++) begin
      checkOutput("beat_valid", 32'(out_valid_o), 32'd1);
      checkOutput("beat_idx",   32'(out_idx_o),   32'(r.idxs[b]));
      checkOutput("beat_last",  32'(out_last_o),  32'(b == int'(r.beats) - 1));
      checkOutput("beat_none",  32'(out_none_o),  32'(r.none));
      checkOutput("beat_busy",  32'(busy_o),      32'd1);
      checkOutput("beat_inrdy", 32'(in_ready_o),  32'd0);
      @(negedge clk);
    end
    checkOutput("post_valid", 32'(out_valid_o), 32'd0);
    checkOutput("post_inrdy", 32'(in_ready_o),  32'd1);
    checkOutput("post_busy",  32'(busy_o),      32'd0);
    checkOutput("post_idx",   32'(out_idx_o),   32'd0);
    checkOutput("post_last",  32'(out_last_o),  32'd0);
  endtask

  // Main sequence: reset, the vector table, then the multi-cycle corner cases.
  initial begin
    int expIdx;
    int cyc;
    logic [3:0] readyPat;

    rst_n       = 1'b0;
    in_valid_i  = 1'b0;
    in_vec_i    = 8'h00;
    out_ready_i = 1'b0;

    tbl[0] = '{vec: 8'hA1, beats: 4'd3, none: 1'b0,
               idxs: {15'd0, 3'd7, 3'd5, 3'd0}};
    tbl[1] = '{vec: 8'h00, beats: 4'd1, none: 1'b1, idxs: 24'd0};
    tbl[2] = '{vec: 8'h01, beats: 4'd1, none: 1'b0, idxs: 24'd0};
    tbl[3] = '{vec: 8'h80, beats: 4'd1, none: 1'b0, idxs: {21'd0, 3'd7}};
    tbl[4] = '{vec: 8'h42, beats: 4'd2, none: 1'b0,
               idxs: {18'd0, 3'd6, 3'd1}};
    tbl[5] = '{vec: 8'h18, beats: 4'd2, none: 1'b0,
               idxs: {18'd0, 3'd4, 3'd3}};

    // Check the output values while reset is held.
    @(negedge clk);
    in_valid_i = 1'b1;
    in_vec_i   = 8'hFF;
    @(negedge clk);
    checkOutput("rst_in_ready",  32'(in_ready_o),  32'd1);
    checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_out_idx",   32'(out_idx_o),   32'd0);
    checkOutput("rst_out_last",  32'(out_last_o),  32'd0);
    checkOutput("rst_out_none",  32'(out_none_o),  32'd0);
    checkOutput("rst_busy",      32'(busy_o),      32'd0);
    in_valid_i = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);

    $display("[TB] running vector table");
    for (int t = 0; t < 6; t++) begin
      runVector(tbl[t]);
    end

    // All ones with a stalling consumer. Each index must hold during a
    // stall, and none may be skipped or repeated.
    $display("[TB] all-ones with stalls");
    readyPat    = 4'b1001;
    out_ready_i = 1'b1;
    applyStimulus(8'hFF);
    expIdx = 0;
    cyc    = 0;
    while (expIdx < 8 && cyc < 40) begin
      out_ready_i = readyPat[cyc % 4];
      checkOutput("ff_valid", 32'(out_valid_o), 32'd1);
      checkOutput("ff_idx",   32'(out_idx_o),   32'(expIdx));
      checkOutput("ff_last",  32'(out_last_o),  32'(expIdx == 7));
      if (out_ready_i) expIdx++;
      cyc++;
      @(negedge clk);
    end
    checkOutput("ff_count",      32'(expIdx),      32'd8);
    checkOutput("ff_post_valid", 32'(out_valid_o), 32'd0);
    checkOutput("ff_post_inrdy", 32'(in_ready_o),  32'd1);

    // Assert reset in the middle of a vector, after index 4 is accepted.
    $display("[TB] reset mid-vector");
    out_ready_i = 1'b1;
    applyStimulus(8'h90);
    checkOutput("rst90_idx4", 32'(out_idx_o), 32'd4);
    @(negedge clk);
    out_ready_i = 1'b0;
    checkOutput("rst90_idx7", 32'(out_idx_o),   32'd7);
    checkOutput("rst90_vld",  32'(out_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst90_async_valid", 32'(out_valid_o), 32'd0);
    checkOutput("rst90_async_busy",  32'(busy_o),      32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rst90_quiet", 32'(out_valid_o), 32'd0);
    end

    // Send 0x01 and then 0x80 back to back with in_valid held high. The
    // second vector must wait for the bubble cycle in IDLE.
    $display("[TB] back-to-back with in_valid held");
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_vec_i    = 8'h01;
    @(negedge clk);
    checkOutput("b2b_v1_valid", 32'(out_valid_o), 32'd1);
    checkOutput("b2b_v1_idx",   32'(out_idx_o),   32'd0);
    checkOutput("b2b_v1_last",  32'(out_last_o),  32'd1);
    checkOutput("b2b_v1_inrdy", 32'(in_ready_o),  32'd0);
    in_vec_i = 8'h80;
    @(negedge clk);
    checkOutput("b2b_bubble_valid", 32'(out_valid_o), 32'd0);
    checkOutput("b2b_bubble_inrdy", 32'(in_ready_o),  32'd1);
    @(negedge clk);
    in_valid_i = 1'b0;
    checkOutput("b2b_v2_valid", 32'(out_valid_o), 32'd1);
    checkOutput("b2b_v2_idx",   32'(out_idx_o),   32'd7);
    checkOutput("b2b_v2_last",  32'(out_last_o),  32'd1);
    checkOutput("b2b_v2_none",  32'(out_none_o),  32'd0);
    @(negedge clk);
    checkOutput("b2b_end_valid", 32'(out_valid_o), 32'd0);
    checkOutput("b2b_end_inrdy", 32'(in_ready_o),  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared,
             mismatched);
    $finish;
  end

endmodule
